// File: rtl/lcd_hd44780_responder.sv
// HD44780-style character LCD responder: bus-side slave that models the
// controller's DDRAM, address counter, busy timing and display-control bits.
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       protocol_error
);

    localparam int MAX_CYC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {ST_INIT_CLR, ST_IDLE, ST_BUSY, ST_CLR} state_t;

    logic srst;
    assign srst = reset_reset;

    // Next AC along the visible lines; line ends wrap onto the other line.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == 7'h27)      ac_step = 7'h40;
            else if (ac == 7'h67) ac_step = 7'h00;
            else                  ac_step = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      ac_step = 7'h67;
            else if (ac == 7'h40) ac_step = 7'h27;
            else                  ac_step = ac - 7'd1;
        end
    endfunction

    function automatic logic [6:0] ac_index(input logic [6:0] ac);
        ac_index = ac[6] ? (7'(ac[5:0]) + 7'd40) : 7'(ac[5:0]);
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        ac_valid = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Synchronizer stages: {e, rs, rw, data}
    logic [10:0] sync1_reg, sync2_reg;
    logic        e_prev_reg;

    logic       e_s, rs_s, rw_s;
    logic [7:0] d_s;
    assign e_s  = sync2_reg[10];
    assign rs_s = sync2_reg[9];
    assign rw_s = sync2_reg[8];
    assign d_s  = sync2_reg[7:0];

    logic e_rise, e_fall;
    assign e_rise = e_s & ~e_prev_reg;
    assign e_fall = ~e_s & e_prev_reg;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [6:0]       sweep_idx_reg;
    logic [6:0]       ac_reg;
    logic             id_reg, s_reg, cg_reg;
    logic             d_reg, c_reg, b_reg;
    logic             read_active_reg, read_rs_reg;
    logic             oe_reg, perr_reg;
    logic [7:0]       data_out_reg;

    logic wr_evt, rd_start;
    assign wr_evt   = e_fall & ~rw_s & ~read_active_reg;
    assign rd_start = e_rise & rw_s;

    // DDRAM and its two registered read ports
    logic [7:0] ddram [0:79];
    logic [7:0] disp_char_reg, ac_rd_reg;
    logic       ram_we;
    logic [6:0] ram_waddr, ac_idx, disp_idx;
    logic [7:0] ram_wdata;

    assign ac_idx   = ac_index(ac_reg);
    assign disp_idx = disp_addr[4] ? (7'(disp_addr[3:0]) + 7'd40) : 7'(disp_addr[3:0]);

    // Single write port: sweep during clears, otherwise accepted data writes
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep_idx_reg;
        ram_wdata = 8'h20;
        if (!srst) begin
            if ((state_reg == ST_INIT_CLR) || (state_reg == ST_CLR)) begin
                ram_we = 1'b1;
            end else if ((state_reg == ST_IDLE) && wr_evt && rs_s && !cg_reg) begin
                ram_we    = 1'b1;
                ram_waddr = ac_idx;
                ram_wdata = d_s;
            end
        end
    end

    // RAM write plus registered reads (read-before-write on a same-cell hit)
    always_ff @(posedge clk_clk) begin
        if (ram_we) ddram[ram_waddr] <= ram_wdata;
        disp_char_reg <= ddram[disp_idx];
        ac_rd_reg     <= ddram[ac_idx];
    end

    // Bus input synchronizer and E edge history
    always_ff @(posedge clk_clk) begin
        if (srst) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            e_prev_reg <= 1'b0;
        end else begin
            sync1_reg  <= {lcd_e, lcd_rs, lcd_rw, lcd_data_in};
            sync2_reg  <= sync1_reg;
            e_prev_reg <= e_s;
        end
    end

    // Controller FSM: sweeps, busy timing, instruction decode and read service
    always_ff @(posedge clk_clk) begin
        if (srst) begin
            state_reg       <= ST_INIT_CLR;
            cnt_reg         <= '0;
            sweep_idx_reg   <= '0;
            ac_reg          <= '0;
            id_reg          <= 1'b1;
            s_reg           <= 1'b0;
            cg_reg          <= 1'b0;
            d_reg           <= 1'b0;
            c_reg           <= 1'b0;
            b_reg           <= 1'b0;
            read_active_reg <= 1'b0;
            read_rs_reg     <= 1'b0;
            oe_reg          <= 1'b0;
            perr_reg        <= 1'b0;
            data_out_reg    <= 8'h00;
        end else begin
            perr_reg <= 1'b0;

            if (rd_start) begin
                data_out_reg    <= rs_s ? ac_rd_reg : {(state_reg != ST_IDLE), ac_reg};
                oe_reg          <= 1'b1;
                read_active_reg <= 1'b1;
                read_rs_reg     <= rs_s;
            end else if (e_fall && read_active_reg) begin
                oe_reg          <= 1'b0;
                read_active_reg <= 1'b0;
                if (read_rs_reg) ac_reg <= ac_step(ac_reg, id_reg);
            end

            if (wr_evt && (state_reg != ST_IDLE)) perr_reg <= 1'b1;

            case (state_reg)
                ST_INIT_CLR, ST_CLR: begin
                    sweep_idx_reg <= sweep_idx_reg + 7'd1;
                    if (sweep_idx_reg == 7'd79) begin
                        if (state_reg == ST_INIT_CLR) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_BUSY;
                            cnt_reg   <= CNT_W'(CLEAR_CYCLES - 80);
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg <= CNT_W'(1)) state_reg <= ST_IDLE;
                    else                      cnt_reg   <= cnt_reg - CNT_W'(1);
                end
                ST_IDLE: begin
                    if (wr_evt) begin
                        state_reg <= ST_BUSY;
                        cnt_reg   <= CNT_W'(BUSY_CYCLES);
                        if (rs_s) begin
                            ac_reg <= ac_step(ac_reg, id_reg);
                        end else begin
                            casez (d_s)
                                8'b1???????: begin
                                    ac_reg <= ac_valid(d_s[6:0]) ? d_s[6:0] : 7'h00;
                                    cg_reg <= 1'b0;
                                end
                                8'b01??????: cg_reg <= 1'b1;
                                8'b001?????: ;
                                8'b0001????: if (!d_s[3]) ac_reg <= ac_step(ac_reg, d_s[2]);
                                8'b00001???: begin
                                    d_reg <= d_s[2];
                                    c_reg <= d_s[1];
                                    b_reg <= d_s[0];
                                end
                                8'b000001??: begin
                                    id_reg <= d_s[1];
                                    s_reg  <= d_s[0];
                                end
                                8'b0000001?: begin
                                    ac_reg  <= 7'h00;
                                    cnt_reg <= CNT_W'(CLEAR_CYCLES);
                                end
                                8'b00000001: begin
                                    state_reg     <= ST_CLR;
                                    sweep_idx_reg <= 7'd0;
                                    ac_reg        <= 7'h00;
                                    id_reg        <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_reg <= ST_INIT_CLR;
            endcase
        end
    end

    // Shift-enable is held for a future display-shift feature
    logic unused_bits;
    assign unused_bits = s_reg;

    assign lcd_data_out   = data_out_reg;
    assign lcd_data_oe    = oe_reg;
    assign disp_char      = disp_char_reg;
    assign display_on     = d_reg;
    assign cursor_on      = c_reg;
    assign blink_on       = b_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign protocol_error = perr_reg;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Randomized scoreboard bench for lcd_hd44780_responder against a
// position-based behavioural model of the display controller.
module tb_lcd_hd44780_responder;

    localparam int BUSY  = 10;
    localparam int CLEAR = 100;

    logic       clk = 1'b0;
    logic       reset_reset;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [4:0] disp_addr;
    logic [7:0] disp_char;
    logic       display_on, cursor_on, blink_on, busy, protocol_error;

    always #5 clk = ~clk;

    lcd_hd44780_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
        .clk_clk(clk), .reset_reset(reset_reset),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out),
        .lcd_data_oe(lcd_data_oe), .disp_addr(disp_addr), .disp_char(disp_char),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .protocol_error(protocol_error)
    );

    int tests = 0;
    int fails = 0;
    int perr_cnt = 0;

    // Reference model: linear cell position 0..79 (line*40 + column)
    logic [7:0] mem_m [80];
    int         pos_m;
    bit         id_m, cg_m;
    bit [2:0]   dcb_m;

    logic [7:0] exp_q [$];
    logic       oe_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pos2ac(input int p);
        return (p < 40) ? p : 64 + p - 40;
    endfunction

    function automatic int ac2pos(input int a);
        return (a >= 64) ? a - 64 + 40 : a;
    endfunction

    function automatic bit addr_ok(input int a);
        return (a <= 39) || (a >= 64 && a <= 103);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
        pos_m = 0; id_m = 1'b1; cg_m = 1'b0; dcb_m = 3'b000;
    endtask

    task automatic model_step(input bit inc);
        pos_m = inc ? (pos_m + 1) % 80 : (pos_m + 79) % 80;
    endtask

    task automatic model_write(input bit rs, input logic [7:0] d, output int blen);
        int v;
        v = d;
        blen = BUSY;
        if (rs) begin
            if (!cg_m) mem_m[pos_m] = d;
            model_step(id_m);
        end else if (v >= 128) begin
            pos_m = addr_ok(v - 128) ? ac2pos(v - 128) : 0;
            cg_m = 1'b0;
        end else if (v >= 64) begin
            cg_m = 1'b1;
        end else if (v >= 32) begin
        end else if (v >= 16) begin
            if (((v / 8) % 2) == 0) model_step(((v / 4) % 2) == 1);
        end else if (v >= 8) begin
            dcb_m = 3'(v % 8);
        end else if (v >= 4) begin
            id_m = ((v / 2) % 2) == 1;
        end else if (v >= 2) begin
            pos_m = 0; blen = CLEAR;
        end else if (v == 1) begin
            for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
            pos_m = 0; id_m = 1'b1; blen = CLEAR;
        end
    endtask

    function automatic logic [7:0] status_exp(input bit b);
        int a;
        a = pos2ac(pos_m);
        return {b, 7'(a)};
    endfunction

    // Monitor: each new read drive on the bus pops one expectation
    always @(negedge clk) begin
        if (lcd_data_oe && !oe_prev) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read actual=%02h required=none", lcd_data_out);
            end else begin
                check("read_data", lcd_data_out, exp_q.pop_front());
            end
        end
        oe_prev = lcd_data_oe;
        if (protocol_error) perr_cnt++;
    end

    task automatic bus_write(input bit rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] write rs=%0d data=%02h", rs, d);
    endtask

    task automatic bus_read(input bit rs, input logic [7:0] exp);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        exp_q.push_back(exp);
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
        check("oe_release", lcd_data_oe, 0);
        $display("[TB] read rs=%0d expect=%02h", rs, exp);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic cycles_to_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic write_checked(input bit rs, input logic [7:0] d);
        int bl, n;
        model_write(rs, d, bl);
        bus_write(rs, d);
        count_busy(n);
        check("busy_len", n, bl);
    endtask

    task automatic check_cells(input string name);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            disp_addr = 5'(a);
            @(negedge clk);
            check(name, disp_char, mem_m[(a / 16) * 40 + (a % 16)]);
        end
    endtask

    task automatic do_reset_checks();
        check("rst_busy", busy, 1);
        check("rst_oe", lcd_data_oe, 0);
        check("rst_dout", lcd_data_out, 0);
        check("rst_dcb", {display_on, cursor_on, blink_on}, 0);
        check("rst_perr", protocol_error, 0);
    endtask

    initial begin
        int n, p0, op;
        logic [7:0] v;

        reset_reset = 1'b1;
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data_in = 8'h00;
        disp_addr = 5'd0;
        model_reset();
        repeat (5) @(negedge clk);
        do_reset_checks();
        reset_reset = 1'b0;
        cycles_to_idle(n);
        check("init_sweep_cycles", n, 80);
        check_cells("init_cells");
        bus_read(0, status_exp(0));

        // Display control
        write_checked(0, 8'h0E);
        check("dcb_0E", {display_on, cursor_on, blink_on}, 3'b110);

        // Line 1 write and status
        write_checked(0, 8'hC0);
        write_checked(1, 8'h41);
        @(negedge clk); disp_addr = 5'd16;
        @(negedge clk); check("cell16", disp_char, 8'h41);
        bus_read(0, status_exp(0));

        // Status and data reads while busy
        model_write(1, 8'h42, n);
        bus_write(1, 8'h42);
        bus_read(0, status_exp(1));
        wait_idle();
        model_write(1, 8'h43, n);
        bus_write(1, 8'h43);
        bus_read(1, mem_m[pos_m]);
        model_step(id_m);
        wait_idle();

        // Line-end wrap in both directions
        write_checked(0, 8'hA7);
        write_checked(1, 8'h5A);
        bus_read(0, status_exp(0));
        write_checked(0, 8'h04);
        write_checked(0, 8'h80);
        write_checked(1, 8'h5B);
        bus_read(0, status_exp(0));
        write_checked(0, 8'h06);

        // Clear with a rejected write during the sweep
        model_write(0, 8'h01, n);
        p0 = perr_cnt;
        bus_write(0, 8'h01);
        fork
            count_busy(n);
            begin
                repeat (5) @(negedge clk);
                bus_write(1, 8'h33);
            end
        join
        check("clear_busy_len", n, CLEAR);
        check("perr_pulses", perr_cnt - p0, 1);
        check_cells("clear_cells");
        bus_read(0, status_exp(0));

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: write_checked(1, 8'($urandom_range(33, 126)));
                2: write_checked(0, 8'(8'h80 | $urandom_range(0, 127)));
                3: write_checked(0, 8'(8'h04 | $urandom_range(0, 3)));
                4: write_checked(0, 8'(8'h10 | $urandom_range(0, 15)));
                5: if (!cg_m) begin
                       bus_read(1, mem_m[pos_m]);
                       model_step(id_m);
                   end
                6: bus_read(0, status_exp(0));
                7: write_checked(0, 8'(8'h08 | $urandom_range(0, 7)));
                8: begin
                       v = ($urandom_range(0, 3) == 0) ? 8'(8'h40 | $urandom_range(0, 63))
                                                       : 8'(8'h20 | $urandom_range(0, 31));
                       write_checked(0, v);
                   end
                default: write_checked(0, 8'(8'h02 | $urandom_range(0, 1)));
            endcase
        end
        check("rand_dcb", {display_on, cursor_on, blink_on}, dcb_m);
        check_cells("rand_cells");
        bus_read(0, status_exp(0));

        // Reset in the middle of a clear sweep
        bus_write(0, 8'h01);
        repeat (20) @(negedge clk);
        reset_reset = 1'b1;
        repeat (3) @(negedge clk);
        do_reset_checks();
        reset_reset = 1'b0;
        model_reset();
        cycles_to_idle(n);
        check("rst_clr_cycles", n, 80);
        check_cells("rst_clr_cells");
        bus_read(0, status_exp(0));

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000, meaning the busy time after an accepted instruction or data write (40 us at 50 MHz).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 82000, meaning the total busy time after clear or return-home (1.64 ms at 50 MHz).
REQ-003 SHALL have ports, one per line:
- clk_clk  in  1  sole clock; all logic on its rising edge.
- reset_reset  in  1  reset, synchronous, active-high.
- lcd_rs  in  1  register select: 0 = instruction/status, 1 = data.
- lcd_rw  in  1  1 = read, 0 = write.
- lcd_e  in  1  enable strobe from the LCD bus initiator.
- lcd_data_in  in  8  bus data from the initiator.
- lcd_data_out  out  8  read data to the initiator.
- lcd_data_oe  out  1  1 = responder drives the bus.
- disp_addr  in  5  visible cell select: 0-15 line 0, 16-31 line 1, columns 0-15.
- disp_char  out  8  character at disp_addr.
- display_on, cursor_on, blink_on  out  1 each  D, C, B bits from display control.
- busy  out  1  busy flag.
- protocol_error  out  1  one-cycle pulse when a write is rejected.

Function
REQ-004 SHALL pass lcd_e, lcd_rs, lcd_rw and lcd_data_in through a 2-flop synchronizer, and SHALL detect E edges on the synchronized signal.
REQ-005 SHALL accept a write on the synchronized E falling edge with rw=0, using the rs and data values from that same synchronized stage.
REQ-006 SHALL start a read on the synchronized E rising edge with rw=1:
- latch lcd_data_out;
- assert lcd_data_oe from the next cycle until the cycle after the falling edge.
REQ-007 Status read (rs=0, rw=1) SHALL return {busy, AC[6:0]} and SHALL be allowed while busy.
REQ-008 SHALL hold an 80-byte DDRAM with a 7-bit address counter AC.
- Valid AC: 0x00-0x27 (line 0) and 0x40-0x67 (line 1).
- Index = line*40 + column.
REQ-009 Instruction decode, by highest set bit:
- 0x01 clear: fill DDRAM with 0x20, AC=0, I/D=1.
- 0x02-03 home: AC=0.
- 0x04-07 entry mode: store I/D (bit1); store S (bit0) without acting on it.
- 0x08-0F display control: store D/C/B.
- 0x10-1F shift: if S/C=0, move AC by R/L with wrap; if S/C=1, no effect.
- 0x20-3F function set: store only.
- 0x40-7F set CGRAM address: set CG mode; later data writes are discarded (AC still advances).
- 0x80-FF set DDRAM address: AC = data[6:0]; an invalid address is forced to 0x00; leaves CG mode.
REQ-010 Data write (rs=1) SHALL store into DDRAM[AC], then step AC by I/D.
REQ-011 Data read (rs=1, rw=1) SHALL return DDRAM[AC] and SHALL step AC on the E falling edge.
REQ-012 AC stepping SHALL wrap as follows:
- increment: 0x27 -> 0x40, 0x67 -> 0x00;
- decrement: 0x00 -> 0x67, 0x40 -> 0x27.
REQ-013 FSM states SHALL be INIT_CLR, IDLE, BUSY and CLR.
- IDLE: writes accepted.
- Normal write: IDLE -> BUSY, busy counter = BUSY_CYCLES.
- Clear: IDLE -> CLR (sweep, one entry per cycle, 80 cycles) -> BUSY with counter = CLEAR_CYCLES-80.
- Home: counter = CLEAR_CYCLES.
- BUSY -> IDLE when the counter reaches 0.
- busy=1 in every state except IDLE.
REQ-014 A write arriving when not in IDLE SHALL be ignored and SHALL pulse protocol_error for 1 cycle.
- Reads SHALL be serviced in all states.
- A data read while busy SHALL return the current DDRAM[AC].
REQ-015 disp_char SHALL be registered, 1-cycle latency, from the DDRAM index for disp_addr.
REQ-016 If a write completion and a disp_addr read hit the same cell in the same cycle, disp_char SHALL show the old value that cycle and the new value on the next.

Reset
REQ-017 While reset_reset=1, outputs SHALL be:
- lcd_data_oe=0, lcd_data_out=0x00;
- protocol_error=0, display_on=cursor_on=blink_on=0;
- busy=1.
REQ-018 Reset SHALL set AC=0, I/D=1, S=0, CG mode off, synchronizers cleared, state INIT_CLR.
REQ-019 After reset release, INIT_CLR SHALL sweep DDRAM to 0x20 over 80 cycles, then go to IDLE with busy=0.
REQ-020 Reset asserted mid-operation (CLR, BUSY, or E high during a read) SHALL abort it immediately and restart INIT_CLR.
- A partial sweep is overwritten by the new sweep.

Verification
REQ-021 Benches SHALL use BUSY_CYCLES=10 and CLEAR_CYCLES=100.
- Reset, then 80 cycles -> busy=0, disp_char=0x20 for all 32 disp_addr.
- Write instr 0x0E -> display_on=1, cursor_on=1, blink_on=0; busy=1 for 10 cycles.
- Write 0xC0, then data 0x41 -> disp_addr=16 gives 0x41; status read returns 0x41 after busy clears.
- Set AC=0x27, write data 0x5A -> AC=0x40; entry 0x04, AC=0x00, data write -> AC=0x67.
- Write 0x01 then another write 5 cycles later -> protocol_error pulse; busy high for 100 cycles; all cells 0x20.
- Reset asserted during CLR sweep -> busy stays 1; IDLE reached exactly 80 cycles after release.
